// File: rtl/sensor_pkg.sv
// Shared definitions for the height-sensor scan interface.
//   DATA_W       default width of one sensor reading
//   NUM_SENSORS  number of height sensors polled per frame
//   SEL_W        width of the sensor index on the read bus
//   FAIL_VALUE   reading reported for a sensor that did not answer; the
//                height logic treats this value as "sensor failed"
//   scan_state_t scan FSM states
package sensor_pkg;

  localparam int DATA_W      = 8;
  localparam int NUM_SENSORS = 4;
  localparam int SEL_W       = 2;

  localparam logic [DATA_W-1:0] FAIL_VALUE = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2,
    PUB  = 2'd3
  } scan_state_t;

endpackage

// File: rtl/sensor_ack_timer.sv
// Wait counter for one bus read.
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   i_clr      synchronous clear (holds the count at zero)
//   i_en       count one cycle of waiting
//   o_expired  high during the LIMIT-th waiting cycle and after
module sensor_ack_timer
  import sensor_pkg::*;
#(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] r_count;

  // The count is 0 in the first waiting cycle, so it reaches LIMIT-1 in the
  // LIMIT-th one; it saturates there so the flag stays up.
  assign o_expired = (r_count == CNT_W'(LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && !o_expired) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sensor_scan_master.sv
// Polls the four height sensors one at a time over a shared req/ack bus and
// publishes all four readings together as one frame.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               one-cycle scan request (ignored while busy)
//   bus_req, bus_sel    read request and sensor index to the bus
//   bus_ack, bus_data   answer from the selected sensor
//   sensor1..sensor4    published readings of sensors 0..3
//   frame_valid         one-cycle pulse when sensor1..4 and fault update
//   fault               bit k set: sensor k timed out in the last frame
//   busy                scan in progress
module sensor_scan_master
  import sensor_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ACK_TIMEOUT = 16,
  parameter int SCAN_PERIOD = 256
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   bus_req,
  output logic [SEL_W-1:0]       bus_sel,
  input  logic                   bus_ack,
  input  logic [DATA_W-1:0]      bus_data,
  output logic [DATA_W-1:0]      sensor1,
  output logic [DATA_W-1:0]      sensor2,
  output logic [DATA_W-1:0]      sensor3,
  output logic [DATA_W-1:0]      sensor4,
  output logic                   frame_valid,
  output logic [NUM_SENSORS-1:0] fault,
  output logic                   busy
);

  scan_state_t            r_state;
  scan_state_t            w_state_next;
  logic [SEL_W-1:0]       r_ch;
  logic [DATA_W-1:0]      r_shadow [NUM_SENSORS];
  logic [NUM_SENSORS-1:0] r_fault_sh;
  logic [DATA_W-1:0]      r_sensor [NUM_SENSORS];
  logic [NUM_SENSORS-1:0] r_fault;
  logic                   r_frame_valid;
  logic                   w_wrap;
  logic                   w_expired;
  logic                   w_timer_clr;

  // Free-running auto-scan period counter; a wrap only matters in IDLE.
  generate
    if (SCAN_PERIOD > 0) begin : g_period
      localparam int PW = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
      logic [PW-1:0] r_period;

      assign w_wrap = (r_period == PW'(SCAN_PERIOD - 1));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_period <= '0;
        end else if (w_wrap) begin
          r_period <= '0;
        end else begin
          r_period <= r_period + PW'(1);
        end
      end
    end else begin : g_no_period
      assign w_wrap = 1'b0;
    end
  endgenerate

  // Held clear outside REQ so every read starts its wait from zero.
  assign w_timer_clr = (r_state != REQ);

  sensor_ack_timer #(
    .LIMIT(ACK_TIMEOUT)
  ) u_ack_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (w_timer_clr),
    .i_en     (bus_req),
    .o_expired(w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    bus_req      = 1'b0;
    busy         = 1'b1;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        // start and a wrap in the same cycle still give a single scan
        if (start || w_wrap) begin
          w_state_next = REQ;
        end
      end
      REQ: begin
        bus_req = 1'b1;
        if (bus_ack || w_expired) begin
          w_state_next = GAP;
        end
      end
      GAP: begin
        w_state_next = (r_ch == SEL_W'(NUM_SENSORS - 1)) ? PUB : REQ;
      end
      PUB: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign bus_sel = r_ch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ch          <= '0;
      r_fault_sh    <= '0;
      r_fault       <= '0;
      r_frame_valid <= 1'b0;
      for (int k = 0; k < NUM_SENSORS; k++) begin
        r_shadow[k] <= '0;
        r_sensor[k] <= '0;
      end
    end else begin
      r_frame_valid <= (r_state == PUB);
      case (r_state)
        IDLE: r_ch <= '0;
        REQ: begin
          // An ack in the expiry cycle is checked first, so it wins.
          if (bus_ack) begin
            r_shadow[r_ch]   <= bus_data;
            r_fault_sh[r_ch] <= 1'b0;
          end else if (w_expired) begin
            r_shadow[r_ch]   <= DATA_W'(FAIL_VALUE);
            r_fault_sh[r_ch] <= 1'b1;
          end
        end
        GAP: r_ch <= r_ch + SEL_W'(1);
        PUB: begin
          // Whole frame moves in one edge; outputs never update piecemeal.
          for (int k = 0; k < NUM_SENSORS; k++) begin
            r_sensor[k] <= r_shadow[k];
          end
          r_fault <= r_fault_sh;
        end
        default: ;
      endcase
    end
  end

  assign sensor1     = r_sensor[0];
  assign sensor2     = r_sensor[1];
  assign sensor3     = r_sensor[2];
  assign sensor4     = r_sensor[3];
  assign fault       = r_fault;
  assign frame_valid = r_frame_valid;

endmodule

// File: tb/tb_sensor_scan_master.sv
// Directed bench for sensor_scan_master: one instance with auto-scan off
// driven by a per-channel configurable sensor model, and one instance with
// SCAN_PERIOD=64 that answers every request immediately.
module tb_sensor_scan_master;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       bus_req;
  logic [1:0] bus_sel;
  logic       bus_ack = 1'b0;
  logic [7:0] bus_data = 8'h00;
  logic [7:0] s1, s2, s3, s4;
  logic       fv;
  logic [3:0] fault;
  logic       busy;

  logic       p_start = 1'b0;
  logic       p_req;
  logic [1:0] p_sel;
  logic       p_ack = 1'b0;
  logic [7:0] p_data = 8'h00;
  logic [7:0] p_s1, p_s2, p_s3, p_s4;
  logic       p_fv;
  logic [3:0] p_fault;
  logic       p_busy;

  always #5 clk = ~clk;

  sensor_scan_master #(.DATA_W(8), .ACK_TIMEOUT(16), .SCAN_PERIOD(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .bus_req(bus_req), .bus_sel(bus_sel), .bus_ack(bus_ack), .bus_data(bus_data),
    .sensor1(s1), .sensor2(s2), .sensor3(s3), .sensor4(s4),
    .frame_valid(fv), .fault(fault), .busy(busy)
  );

  sensor_scan_master #(.DATA_W(8), .ACK_TIMEOUT(16), .SCAN_PERIOD(64)) dut_p (
    .clk(clk), .rst_n(rst_n), .start(p_start),
    .bus_req(p_req), .bus_sel(p_sel), .bus_ack(p_ack), .bus_data(p_data),
    .sensor1(p_s1), .sensor2(p_s2), .sensor3(p_s3), .sensor4(p_s4),
    .frame_valid(p_fv), .fault(p_fault), .busy(p_busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Sensor model configuration: ack in req cycle dly[ch]+1, answer val[ch].
  int         dly [4];
  logic [7:0] val [4];
  bit         spur = 1'b0;

  // Bus observations
  int         req_cnt = 0;
  int         gap_cnt = 0;
  int         last_len [4];
  logic [7:0] sel_log = 8'h00;
  logic [7:0] gap_log = 8'h00;
  int         fv_cnt = 0;

  // Sensor model + monitor, sampled 1 time unit after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (fv) fv_cnt++;
      if (bus_req) begin
        req_cnt++;
        if (req_cnt == 1) begin
          sel_log = {sel_log[5:0], bus_sel};
          gap_log = {gap_log[5:0], 2'(gap_cnt)};
          gap_cnt = 0;
        end
        last_len[bus_sel] = req_cnt;
      end else begin
        req_cnt = 0;
        if (busy) gap_cnt++;
        else gap_cnt = 0;
      end
      bus_ack  = 1'b0;
      bus_data = 8'hEE;
      if (bus_req && req_cnt == dly[bus_sel] + 1) begin
        bus_ack  = 1'b1;
        bus_data = val[bus_sel];
      end else if (!bus_req && spur) begin
        bus_ack = 1'b1;
      end
      p_ack  = p_req;
      p_data = 8'hA0 + {6'd0, p_sel};
    end
  end

  task automatic set_cfg(input int d0, d1, d2, d3, input logic [31:0] v);
    dly[0] = d0; dly[1] = d1; dly[2] = d2; dly[3] = d3;
    val[0] = v[31:24]; val[1] = v[23:16]; val[2] = v[15:8]; val[3] = v[7:0];
  endtask

  task automatic run_scan(input string tag, input int mid_start, input int exp_lat,
                          input logic [31:0] exp_s, input logic [3:0] exp_f);
    int n;
    int fv0;
    fv0 = fv_cnt;
    @(posedge clk); #2; start = 1'b1;
    @(posedge clk); #2; start = 1'b0;
    n = 0;
    while (!fv && n < 200) begin
      @(posedge clk); #2;
      n++;
      start = (n == mid_start);
    end
    start = 1'b0;
    $display("scan %s latency=%0d sensors=%h fault=%b", tag, n, {s1, s2, s3, s4}, fault);
    chk({tag, ".latency"}, n, exp_lat);
    chk({tag, ".sensors"}, {s1, s2, s3, s4}, exp_s);
    chk({tag, ".fault"}, {28'd0, fault}, {28'd0, exp_f});
    chk({tag, ".sel_order"}, {24'd0, sel_log}, 32'h1B);
    chk({tag, ".gaps"}, {24'd0, gap_log}, 32'h15);
    repeat (20) @(posedge clk);
    #2;
    chk({tag, ".one_frame"}, fv_cnt - fv0, 1);
    chk({tag, ".idle"}, {31'd0, busy}, 0);
    chk({tag, ".hold"}, {s1, s2, s3, s4}, exp_s);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int n;
    int fv0;
    set_cfg(1, 1, 1, 1, 32'h10203040);

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    chk("rst.sensors", {s1, s2, s3, s4}, 0);
    chk("rst.ctl", {26'd0, fault, fv, busy}, 0);
    chk("rst.bus_req", {31'd0, bus_req}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("idle.busy", {31'd0, busy}, 0);

    // 1: all sensors answer one cycle after req
    run_scan("t1", 0, 13, 32'h10203040, 4'b0000);
    chk("t1.req_len0", last_len[0], 2);
    chk("t1.req_len3", last_len[3], 2);

    // 2: sensor 2 never answers
    set_cfg(1, 1, 1000, 1, 32'h55555555);
    run_scan("t2", 0, 27, 32'h55550055, 4'b0100);
    chk("t2.req_len2", last_len[2], 16);

    // 3: sensor 1 answers in the timeout cycle
    set_cfg(1, 15, 1, 1, 32'h13773334);
    run_scan("t3", 0, 27, 32'h13773334, 4'b0000);
    chk("t3.req_len1", last_len[1], 16);

    // 4: start during scan and spurious acks while bus_req=0
    set_cfg(1, 1, 1, 1, 32'h11223344);
    spur = 1'b1;
    run_scan("t4", 5, 13, 32'h11223344, 4'b0000);
    spur = 1'b0;

    // 5: reset during the channel-2 read
    set_cfg(1, 1, 1, 1, 32'h91929394);
    @(posedge clk); #2; start = 1'b1;
    @(posedge clk); #2; start = 1'b0;
    n = 0;
    while (!(bus_req && bus_sel == 2'd2) && n < 50) begin
      @(posedge clk); #2;
      n++;
    end
    chk("t5.reach_ch2", {31'd0, n < 50}, 1);
    fv0 = fv_cnt;
    #1 rst_n = 1'b0;
    #1;
    chk("t5.async_sensors", {s1, s2, s3, s4}, 0);
    chk("t5.async_ctl", {26'd0, fault, fv, busy}, 0);
    chk("t5.async_req", {31'd0, bus_req}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    chk("t5.no_frame", fv_cnt - fv0, 0);
    chk("t5.no_partial", {s1, s2, s3, s4}, 0);
    $display("reset abort sensors=%h frames=%0d", {s1, s2, s3, s4}, fv_cnt - fv0);
    run_scan("t5", 0, 13, 32'h91929394, 4'b0000);

    // 6: auto-scan instance, frame every 64 cycles with no start
    n = 0;
    while (!p_fv && n < 300) begin
      @(posedge clk); #2;
      n++;
    end
    chk("t6.first", {31'd0, p_fv}, 1);
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin
        @(posedge clk); #2;
        n++;
        if (n == 32) chk("t6.mid_hold", {p_s1, p_s2, p_s3, p_s4}, 32'hA0A1A2A3);
      end while (!p_fv && n < 300);
      $display("period frame %0d interval=%0d sensors=%h", k, n, {p_s1, p_s2, p_s3, p_s4});
      chk("t6.interval", n, 64);
      chk("t6.sensors", {p_s1, p_s2, p_s3, p_s4}, 32'hA0A1A2A3);
      chk("t6.fault", {28'd0, p_fault}, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
